// File: rtl/seg7_mux_driver.sv
// Time-multiplexed seven-segment display driver with a load handshake.
// Hex mode updates the display directly. Decimal mode runs a sequential
// double-dabble conversion, then commits the BCD digits atomically.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_mux_driver #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned VALUE_W     = 16,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter bit          ACTIVE_LOW  = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [VALUE_W-1:0] value,
  input  logic               load,
  input  logic               mode,
  output logic               busy,
  output logic [6:0]         sevent,
  output logic [DIGITS-1:0]  enable
);

  localparam int unsigned DispW     = 4 * DIGITS;
  localparam int unsigned BcdMin    = (VALUE_W * 3) / 10 + 1;
  localparam int unsigned BcdDigits = (BcdMin > DIGITS) ? BcdMin : DIGITS;
  localparam int unsigned BcdW      = 4 * BcdDigits;
  localparam int unsigned RefW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned DigW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned CntW      = $clog2(VALUE_W + 1);
  localparam longint unsigned DecLimit = 64'd10 ** DIGITS;

  // Segment patterns in active-low gfedcba form.
  localparam logic [6:0] SegZero  = 7'b1000000;
  localparam logic [6:0] SegDash  = 7'b0111111;
  localparam logic [6:0] SegBlank = 7'b1111111;

  localparam logic [6:0]        SevRst = ACTIVE_LOW ? SegZero : ~SegZero;
  localparam logic [DIGITS-1:0] EnRst  = ACTIVE_LOW ? ~DIGITS'(1) : DIGITS'(1);

  typedef enum logic [1:0] {StIdle, StConv, StCommit} state_e;

  state_e              state_q, state_d;
  logic [VALUE_W-1:0]  bin_q, bin_d;
  logic [BcdW-1:0]     bcd_q, bcd_d, bcd_adj;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                ovf_pend_q, ovf_pend_d;
  logic [DispW-1:0]    disp_q, disp_d;
  logic                ovf_q, ovf_d;
  logic [RefW-1:0]     ref_q, ref_d;
  logic [DigW-1:0]     dig_q, dig_d;
  logic [6:0]          sevent_q, sevent_d;
  logic [DIGITS-1:0]   enable_q, enable_d;

  logic [63:0]         value_ext;
  logic                hex_ovf;
  logic                blank;
  logic [3:0]          nib;
  logic [6:0]          seg_al;
  logic [DIGITS-1:0]   en_hot;
  int unsigned         dig_idx;

  function automatic logic [6:0] seg_lut(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign value_ext = 64'(value);
  assign hex_ovf   = (value_ext >> DispW) != 64'd0;
  assign busy      = (state_q == StConv) || (state_q == StCommit);
  assign sevent    = sevent_q;
  assign enable    = enable_q;

  // Double-dabble add-3 adjustment on every BCD digit of the running result.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < int'(BcdDigits); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Load handshake, conversion sequencing and display-register update.
  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    disp_d     = disp_q;
    ovf_d      = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (load) begin
          if (mode) begin
            bin_d      = value;
            bcd_d      = '0;
            cnt_d      = '0;
            ovf_pend_d = (value_ext >= DecLimit);
            state_d    = StConv;
          end else begin
            disp_d = value_ext[DispW-1:0];
            ovf_d  = hex_ovf;
          end
        end
      end
      StConv: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        cnt_d          = cnt_q + CntW'(1);
        if (cnt_q == CntW'(VALUE_W - 1)) state_d = StCommit;
      end
      StCommit: begin
        // Digits and overflow land together so the display never shows a mix.
        disp_d  = bcd_q[DispW-1:0];
        ovf_d   = ovf_pend_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Refresh timer and digit-index advance.
  always_comb begin
    ref_d = ref_q + RefW'(1);
    dig_d = dig_q;
    if (ref_q == RefW'(REFRESH_DIV - 1)) begin
      ref_d = '0;
      dig_d = (dig_q == DigW'(DIGITS - 1)) ? '0 : dig_q + DigW'(1);
    end
  end

  // Pin values from the current digit index and display register.
  always_comb begin
    dig_idx = 32'(dig_q);
    nib     = disp_q[4*dig_idx +: 4];
`ifdef SEG7_LZB_EN
    blank   = (dig_q != '0) && ((disp_q >> (4 * dig_idx)) == '0);
`else
    blank   = 1'b0;
`endif
    if (ovf_q)      seg_al = SegDash;
    else if (blank) seg_al = SegBlank;
    else            seg_al = seg_lut(nib);
    en_hot   = DIGITS'(1) << dig_q;
    sevent_d = ACTIVE_LOW ? seg_al : ~seg_al;
    enable_d = ACTIVE_LOW ? ~en_hot : en_hot;
  end

  // State, datapath, refresh and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      disp_q     <= '0;
      ovf_q      <= 1'b0;
      ref_q      <= '0;
      dig_q      <= '0;
      sevent_q   <= SevRst;
      enable_q   <= EnRst;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      disp_q     <= disp_d;
      ovf_q      <= ovf_d;
      ref_q      <= ref_d;
      dig_q      <= dig_d;
      sevent_q   <= sevent_d;
      enable_q   <= enable_d;
    end
  end

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Self-checking bench for seg7_mux_driver: directed vector table, multi-cycle
// handshake/reset sequences and randomized traffic against a behavioural model.
// Define SEG7_LZB_EN for both bench and RTL to exercise leading-zero blanking.
module tb_seg7_mux_driver;

  localparam int unsigned DIGITS      = 4;
  localparam int unsigned VALUE_W     = 16;
  localparam int unsigned REFRESH_DIV = 4;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  localparam logic [6:0] DASH = 7'b0111111;
  localparam logic [6:0] BL   = 7'b1111111;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [VALUE_W-1:0] value = '0;
  logic               load = 1'b0;
  logic               mode = 1'b0;
  logic               busy;
  logic [6:0]         sevent;
  logic [DIGITS-1:0]  enable;

  int n_checks = 0;
  int n_errors = 0;

  seg7_mux_driver #(
    .DIGITS     (DIGITS),
    .VALUE_W    (VALUE_W),
    .REFRESH_DIV(REFRESH_DIV),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .value (value),
    .load  (load),
    .mode  (mode),
    .busy  (busy),
    .sevent(sevent),
    .enable(enable)
  );

  always #5 clk = ~clk;

  // Behavioural model: elapsed cycles, shown digits as integers, pending conversion.
  int          m_tick = 0;
  int          m_disp [DIGITS];
  bit          m_ovf = 1'b0;
  int          m_pend = 0;
  int unsigned m_conv_val = 0;
  bit          m_conv_ovf = 1'b0;
  bit          m_valid = 1'b0;

  function automatic int unsigned pow_int(input int unsigned b, input int n);
    int unsigned p = 1;
    for (int i = 0; i < n; i++) p = p * b;
    return p;
  endfunction

  function automatic int model_digit();
    return (m_tick / REFRESH_DIV) % DIGITS;
  endfunction

  function automatic logic [DIGITS-1:0] model_en();
    logic [DIGITS-1:0] one = 1;
    return ~(one << model_digit());
  endfunction

  function automatic logic [6:0] model_seg();
    int d = model_digit();
`ifdef SEG7_LZB_EN
    int msd = -1;
`endif
    if (m_ovf) return DASH;
`ifdef SEG7_LZB_EN
    for (int k = 0; k < DIGITS; k++) if (m_disp[k] != 0) msd = k;
    if (d > 0 && d > msd) return BL;
`endif
    return SEG_TAB[m_disp[d]];
  endfunction

  task automatic model_step(input logic r, input logic ld, input logic md,
                            input logic [VALUE_W-1:0] v);
    if (r) begin
      m_tick = 0;
      for (int k = 0; k < DIGITS; k++) m_disp[k] = 0;
      m_ovf  = 1'b0;
      m_pend = 0;
    end else begin
      m_tick++;
      if (m_pend > 0) begin
        m_pend--;
        if (m_pend == 0) begin
          for (int k = 0; k < DIGITS; k++)
            m_disp[k] = int'((m_conv_val / pow_int(10, k)) % 10);
          m_ovf = m_conv_ovf;
        end
      end else if (ld) begin
        if (md) begin
          m_conv_val = int'(v);
          m_conv_ovf = (int'(v) >= pow_int(10, DIGITS));
          m_pend     = VALUE_W + 1;
        end else begin
          for (int k = 0; k < DIGITS; k++) m_disp[k] = int'((int'(v) >> (4 * k)) & 15);
          m_ovf = (int'(v) >= pow_int(16, DIGITS));
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model, compare all outputs after the edge.
  task automatic cycle(input logic r, input logic ld, input logic md,
                       input logic [VALUE_W-1:0] v);
    logic [6:0]        e_sev;
    logic [DIGITS-1:0] e_en;
    rst = r; load = ld; mode = md; value = v;
    if (r) begin
      e_sev = SEG_TAB[0];
      e_en  = ~DIGITS'(1);
    end else begin
      e_sev = model_seg();
      e_en  = model_en();
    end
    @(posedge clk);
    model_step(r, ld, md, v);
    #1;
    if (r) m_valid = 1'b1;
    if (m_valid) begin
      chk("busy",   32'(busy),   32'(m_pend > 0));
      chk("enable", 32'(enable), 32'(e_en));
      chk("sevent", 32'(sevent), 32'(e_sev));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic wait_not_busy();
    int n = 0;
    while (busy === 1'b1 && n < 60) begin idle(1); n++; end
    if (busy !== 1'b0) begin
      n_checks++; n_errors++;
      $display("FAIL busy_timeout: busy %b expected 0", busy);
    end
  endtask

  // Wait for digit k to be lit, then compare its segments.
  task automatic show_digit(input int vi, input int k, input logic [6:0] exp);
    logic [DIGITS-1:0] want = ~(DIGITS'(1) << k);
    int n = 0;
    while (enable !== want && n < 4 * DIGITS * REFRESH_DIV + 4) begin idle(1); n++; end
    if (enable !== want) begin
      n_checks++; n_errors++;
      $display("FAIL scan_timeout vec%0d digit%0d: enable %b expected %b", vi, k, enable, want);
    end else begin
      chk($sformatf("vec%0d_digit%0d", vi, k), 32'(sevent), 32'(exp));
    end
  endtask

  task automatic scan_all(input int vi, input logic [27:0] segs);
    for (int k = 0; k < DIGITS; k++) show_digit(vi, k, segs[7*k +: 7]);
  endtask

  typedef struct packed {
    logic        dec;
    logic [15:0] val;
    logic [27:0] segs;  // {digit3, digit2, digit1, digit0}
  } vec_t;

  vec_t vecs [10];

  initial begin
    int busy_len;
    logic [27:0] zero_segs;
    vecs[0] = '{dec: 1'b0, val: 16'hBEEF,
                segs: {SEG_TAB[11], SEG_TAB[14], SEG_TAB[14], SEG_TAB[15]}};
    vecs[1] = '{dec: 1'b1, val: 16'd1234,
                segs: {SEG_TAB[1], SEG_TAB[2], SEG_TAB[3], SEG_TAB[4]}};
    vecs[2] = '{dec: 1'b1, val: 16'd10000, segs: {DASH, DASH, DASH, DASH}};
    vecs[3] = '{dec: 1'b1, val: 16'd65535, segs: {DASH, DASH, DASH, DASH}};
    vecs[4] = '{dec: 1'b1, val: 16'd9999,
                segs: {SEG_TAB[9], SEG_TAB[9], SEG_TAB[9], SEG_TAB[9]}};
    vecs[5] = '{dec: 1'b0, val: 16'h1000,
                segs: {SEG_TAB[1], SEG_TAB[0], SEG_TAB[0], SEG_TAB[0]}};
`ifdef SEG7_LZB_EN
    vecs[6] = '{dec: 1'b0, val: 16'h00A5, segs: {BL, BL, SEG_TAB[10], SEG_TAB[5]}};
    vecs[7] = '{dec: 1'b1, val: 16'd7,    segs: {BL, BL, BL, SEG_TAB[7]}};
    vecs[8] = '{dec: 1'b0, val: 16'h0000, segs: {BL, BL, BL, SEG_TAB[0]}};
    vecs[9] = '{dec: 1'b1, val: 16'd0,    segs: {BL, BL, BL, SEG_TAB[0]}};
    zero_segs = {BL, BL, BL, SEG_TAB[0]};
`else
    vecs[6] = '{dec: 1'b0, val: 16'h00A5,
                segs: {SEG_TAB[0], SEG_TAB[0], SEG_TAB[10], SEG_TAB[5]}};
    vecs[7] = '{dec: 1'b1, val: 16'd7,
                segs: {SEG_TAB[0], SEG_TAB[0], SEG_TAB[0], SEG_TAB[7]}};
    vecs[8] = '{dec: 1'b0, val: 16'h0000,
                segs: {SEG_TAB[0], SEG_TAB[0], SEG_TAB[0], SEG_TAB[0]}};
    vecs[9] = '{dec: 1'b1, val: 16'd0,
                segs: {SEG_TAB[0], SEG_TAB[0], SEG_TAB[0], SEG_TAB[0]}};
    zero_segs = {SEG_TAB[0], SEG_TAB[0], SEG_TAB[0], SEG_TAB[0]};
`endif
    for (int k = 0; k < DIGITS; k++) m_disp[k] = 0;

    // Reset held for two cycles, then free-running refresh.
    cycle(1'b1, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b0, '0);
    idle(2 * DIGITS * REFRESH_DIV + 2);

    // Directed vectors.
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b1, vecs[i].dec, vecs[i].val);
      wait_not_busy();
      idle(2);
      scan_all(i, vecs[i].segs);
    end

    // Decimal busy window length.
    cycle(1'b0, 1'b1, 1'b1, 16'd1234);
    busy_len = 0;
    while (busy === 1'b1 && busy_len < 100) begin busy_len++; idle(1); end
    chk("busy_len", 32'(busy_len), 32'(VALUE_W + 1));

    // Loads during busy are ignored.
    cycle(1'b0, 1'b1, 1'b1, 16'd4321);
    idle(3);
    cycle(1'b0, 1'b1, 1'b1, 16'd5);
    cycle(1'b0, 1'b1, 1'b0, 16'h5555);
    wait_not_busy();
    idle(2);
    scan_all(20, {SEG_TAB[4], SEG_TAB[3], SEG_TAB[2], SEG_TAB[1]});

    // Reset in the middle of a conversion.
    cycle(1'b0, 1'b1, 1'b1, 16'd8765);
    idle(5);
    cycle(1'b1, 1'b0, 1'b0, '0);
    chk("busy_after_rst", 32'(busy), 32'd0);
    idle(2);
    scan_all(21, zero_segs);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      int unsigned r = $urandom_range(0, 199);
      logic [VALUE_W-1:0] v;
      v = ($urandom_range(0, 2) == 0) ? VALUE_W'($urandom) : VALUE_W'($urandom_range(0, 12000));
      cycle(r == 0, r < 50, 1'($urandom), v);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
